// File: rtl/store_buffer.sv
// Store buffer ahead of the data-memory write port: checks and queues sw/sh/sb
// requests, drains one per cycle in FIFO order, and flags loads that hit a pending store.
module store_buffer #(
  parameter int          DEPTH    = 4,
  parameter int          PW       = 2,
  parameter logic [31:0] ADDR_MAX = 32'h0000_2fff
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [1:0]    st_op,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_wdata,
  output logic          st_ready,
  output logic          st_err,
  input  logic          ld_check,
  input  logic [31:0]   ld_addr,
  output logic          ld_hazard,
  input  logic          drain_en,
  output logic          dm_we,
  output logic [31:0]   dm_addr,
  output logic [31:0]   dm_wd,
  output logic [3:0]    dm_be,
  output logic [PW:0]   count,
  output logic          empty,
  output logic          full
);

  // Only the word address is kept; byte position lives in the byte enables.
  logic [29:0]   r_addr  [DEPTH];
  logic [31:0]   r_wdata [DEPTH];
  logic [3:0]    r_be    [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          r_st_err;

  logic          w_bad_op;
  logic          w_bad;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [3:0]    w_be;
  logic          w_hazard;
  logic          w_ld_unused;

  function automatic logic [3:0] be_enc(input logic [1:0] op, input logic [1:0] a);
    logic [3:0] be;
    case (op)
      2'b00:   be = 4'b1111;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b0001 << a;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  assign w_empty     = (r_count == (PW+1)'(0));
  assign w_full      = (r_count == (PW+1)'(DEPTH));
  assign w_bad       = w_bad_op || (st_addr > ADDR_MAX);
  assign w_push      = st_valid && !w_full && !w_bad;
  assign w_pop       = !w_empty && drain_en;
  assign w_be        = be_enc(st_op, st_addr[1:0]);
  assign w_ld_unused = ^ld_addr[1:0];

  // Alignment legality per store width.
  always_comb begin
    w_bad_op = 1'b0;
    case (st_op)
      2'b00:   w_bad_op = (st_addr[1:0] != 2'b00);
      2'b01:   w_bad_op = st_addr[0];
      2'b10:   w_bad_op = 1'b0;
      default: w_bad_op = 1'b1;
    endcase
  end

  // FIFO state, entry storage and the error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_st_err <= 1'b0;
    end else begin
      r_st_err <= st_valid && w_bad;
      if (w_push) begin
        r_addr[r_wr_ptr]  <= st_addr[31:2];
        r_wdata[r_wr_ptr] <= st_wdata;
        r_be[r_wr_ptr]    <= w_be;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry drives the memory port; zeros when nothing is pending.
  always_comb begin
    dm_addr = 32'h0000_0000;
    dm_wd   = 32'h0000_0000;
    dm_be   = 4'b0000;
    if (!w_empty) begin
      dm_addr = {r_addr[r_rd_ptr], 2'b00};
      dm_wd   = r_wdata[r_rd_ptr];
      dm_be   = r_be[r_rd_ptr];
    end else begin
      dm_addr = 32'h0000_0000;
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(i) - r_rd_ptr} < r_count) && (r_addr[i] == ld_addr[31:2])) begin
        w_hazard = 1'b1;
      end else begin
        w_hazard = w_hazard;
      end
    end
  end

  assign ld_hazard = ld_check && w_hazard;
  assign dm_we     = w_pop && !reset;
  assign st_ready  = !w_full;
  assign st_err    = r_st_err;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: drain path, ordering, full/wrap,
// rejection pulses, load hazards and reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic        st_ready;
  logic        st_err;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        drain_en;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [3:0]  dm_be;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int total = 0;
  int bad   = 0;

  store_buffer #(.DEPTH(4), .PW(2), .ADDR_MAX(32'h0000_2fff)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_ready(st_ready), .st_err(st_err),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .drain_en(drain_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_be(dm_be),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = a;
    st_wdata = d;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_op = 2'b00; st_addr = 32'h0; st_wdata = 32'h0;
    ld_check = 1'b0; ld_addr = 32'h0; drain_en = 1'b0;
    step();
    chk("rst_dm_we", 32'(dm_we), 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_ready", 32'(st_ready), 32'h1);
    chk("rst_err", 32'(st_err), 32'h0);
    chk("rst_hazard", 32'(ld_hazard), 32'h0);

    // Single sw drains the cycle after it is pushed.
    drain_en = 1'b1;
    put(2'b00, 32'h0000_0010, 32'h1234_5678);
    step();
    st_valid = 1'b0;
    #1;
    chk("sw_we", 32'(dm_we), 32'h1);
    chk("sw_addr", dm_addr, 32'h0000_0010);
    chk("sw_be", 32'(dm_be), 32'hf);
    chk("sw_wd", dm_wd, 32'h1234_5678);
    chk("sw_count", 32'(count), 32'h1);
    step();
    chk("sw_empty", 32'(empty), 32'h1);
    chk("sw_we_off", 32'(dm_we), 32'h0);
    chk("empty_addr", dm_addr, 32'h0);

    // sb then sh, held then drained in order.
    drain_en = 1'b0;
    put(2'b10, 32'h0000_0007, 32'h0000_00AB);
    step();
    put(2'b01, 32'h0000_000A, 32'h0000_CDEF);
    step();
    st_valid = 1'b0;
    #1;
    chk("hold_count", 32'(count), 32'h2);
    chk("hold_we", 32'(dm_we), 32'h0);
    drain_en = 1'b1;
    #1;
    chk("sb_we", 32'(dm_we), 32'h1);
    chk("sb_be", 32'(dm_be), 32'h8);
    chk("sb_addr", dm_addr, 32'h0000_0004);
    chk("sb_wd", dm_wd, 32'h0000_00AB);
    step();
    chk("sh_be", 32'(dm_be), 32'hc);
    chk("sh_addr", dm_addr, 32'h0000_0008);
    chk("sh_wd", dm_wd, 32'h0000_CDEF);
    step();
    chk("sbsh_empty", 32'(empty), 32'h1);

    // Fill to full; the fifth store is ignored without an error.
    drain_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      put(2'b00, 32'h0000_0100 + 32'(4 * k), 32'(k + 1));
      #1;
      if (k == 4) begin
        chk("full_ready", 32'(st_ready), 32'h0);
        chk("full_flag", 32'(full), 32'h1);
      end else begin
        chk("fill_ready", 32'(st_ready), 32'h1);
      end
      step();
    end
    st_valid = 1'b0;
    #1;
    chk("full_count", 32'(count), 32'h4);
    chk("full_no_err", 32'(st_err), 32'h0);
    drain_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fill_we", 32'(dm_we), 32'h1);
      chk("fill_addr", dm_addr, 32'h0000_0100 + 32'(4 * k));
      chk("fill_wd", dm_wd, 32'(k + 1));
      step();
    end
    chk("fill_empty", 32'(empty), 32'h1);

    // Streaming push/pop across several pointer wraps.
    for (int k = 0; k < 10; k++) begin
      put(2'b00, 32'h0000_0200 + 32'(4 * k), 32'h0000_00A0 + 32'(k));
      #1;
      if (k > 0) begin
        chk("wrap_addr", dm_addr, 32'h0000_0200 + 32'(4 * (k - 1)));
        chk("wrap_wd", dm_wd, 32'h0000_00A0 + 32'(k - 1));
        chk("wrap_count", 32'(count), 32'h1);
      end else begin
        chk("wrap_start", 32'(count), 32'h0);
      end
      step();
    end
    st_valid = 1'b0;
    #1;
    chk("wrap_last", dm_addr, 32'h0000_0224);
    step();
    chk("wrap_empty", 32'(empty), 32'h1);

    // Rejected requests: one-cycle error pulse, nothing enqueued.
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       put(2'b00, 32'h0000_0002, 32'h1);
        1:       put(2'b01, 32'h0000_0003, 32'h2);
        2:       put(2'b11, 32'h0000_0000, 32'h3);
        default: put(2'b00, 32'h0000_3000, 32'h4);
      endcase
      step();
      st_valid = 1'b0;
      #1;
      chk("rej_err", 32'(st_err), 32'h1);
      chk("rej_count", 32'(count), 32'h0);
      step();
      chk("rej_err_clr", 32'(st_err), 32'h0);
    end
    put(2'b10, 32'h0000_2fff, 32'h0000_0055);
    step();
    st_valid = 1'b0;
    #1;
    chk("edge_err", 32'(st_err), 32'h0);
    chk("edge_addr", dm_addr, 32'h0000_2ffc);
    chk("edge_be", 32'(dm_be), 32'h8);
    step();

    // Load hazard against a pending byte store.
    drain_en = 1'b0;
    put(2'b10, 32'h0000_0021, 32'h0000_005A);
    step();
    st_valid = 1'b0;
    ld_check = 1'b1; ld_addr = 32'h0000_0020;
    #1;
    chk("hz_hit", 32'(ld_hazard), 32'h1);
    ld_addr = 32'h0000_0024;
    #1;
    chk("hz_miss", 32'(ld_hazard), 32'h0);
    ld_check = 1'b0; ld_addr = 32'h0000_0020;
    #1;
    chk("hz_noload", 32'(ld_hazard), 32'h0);
    ld_check = 1'b1; ld_addr = 32'h0000_0023;
    drain_en = 1'b1;
    #1;
    chk("hz_draining", 32'(ld_hazard), 32'h1);
    chk("hz_be", 32'(dm_be), 32'h2);
    step();
    chk("hz_after", 32'(ld_hazard), 32'h0);
    ld_check = 1'b0;

    // Reset discards pending entries and blocks the memory write.
    drain_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(2'b00, 32'h0000_0300 + 32'(4 * k), 32'(k));
      step();
    end
    st_valid = 1'b0;
    #1;
    chk("pre_rst_count", 32'(count), 32'h3);
    reset = 1'b1; drain_en = 1'b1;
    #1;
    chk("rst_we_block", 32'(dm_we), 32'h0);
    step();
    reset = 1'b0; drain_en = 1'b0;
    ld_check = 1'b1; ld_addr = 32'h0000_0300;
    #1;
    chk("post_rst_count", 32'(count), 32'h0);
    chk("post_rst_empty", 32'(empty), 32'h1);
    chk("post_rst_hazard", 32'(ld_hazard), 32'h0);
    ld_check = 1'b0;
    drain_en = 1'b1;
    put(2'b00, 32'h0000_0400, 32'h0000_BEEF);
    step();
    st_valid = 1'b0;
    #1;
    chk("post_rst_we", 32'(dm_we), 32'h1);
    chk("post_rst_addr", dm_addr, 32'h0000_0400);
    chk("post_rst_wd", dm_wd, 32'h0000_BEEF);
    step();
    chk("final_empty", 32'(empty), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
